cpu0_fetch: RTL and testbench

Instruction prefetch unit for the CPU0 core. It reads instruction bytes from a byte-wide memory port and assembles them big-endian into 32-bit words, ordered {m[pc], m[pc+1], m[pc+2], m[pc+3]}. Assembled words are buffered, each with its address, in a small queue. The execute stage consumes them through a valid/ready handshake and flushes the queue with a redirect on any taken jump, CALL, RET, SWI or IRET.

---
 rtl/cpu0_pkg.sv | 62 ++++++
 rtl/cpu0_ifq.sv | 79 +++++++
 rtl/cpu0_fetch.sv | 132 +++++++++++++
 tb/tb_cpu0_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu0_pkg
//  Description : Shared CPU0 definitions: datapath width, opcode constants,
//                fetch state encoding and a word-alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu0_pkg;

   localparam int WORD_W = 32;

   // Opcode map shared by the core and its benches
   localparam logic [7:0] LD    = 8'h00;
   localparam logic [7:0] ST    = 8'h01;
   localparam logic [7:0] LDB   = 8'h02;
   localparam logic [7:0] STB   = 8'h03;
   localparam logic [7:0] LDR   = 8'h04;
   localparam logic [7:0] STR   = 8'h05;
   localparam logic [7:0] LBR   = 8'h06;
   localparam logic [7:0] SBR   = 8'h07;
   localparam logic [7:0] LDI   = 8'h08;
   localparam logic [7:0] CMP   = 8'h10;
   localparam logic [7:0] MOV   = 8'h12;
   localparam logic [7:0] ADD   = 8'h13;
   localparam logic [7:0] SUB   = 8'h14;
   localparam logic [7:0] MUL   = 8'h15;
   localparam logic [7:0] DIV   = 8'h16;
   localparam logic [7:0] AND   = 8'h18;
   localparam logic [7:0] OR    = 8'h19;
   localparam logic [7:0] XOR   = 8'h1A;
   localparam logic [7:0] ROL   = 8'h1C;
   localparam logic [7:0] ROR   = 8'h1D;
   localparam logic [7:0] SHL   = 8'h1E;
   localparam logic [7:0] SHR   = 8'h1F;
   localparam logic [7:0] JEQ   = 8'h20;
   localparam logic [7:0] JNE   = 8'h21;
   localparam logic [7:0] JLT   = 8'h22;
   localparam logic [7:0] JGT   = 8'h23;
   localparam logic [7:0] JLE   = 8'h24;
   localparam logic [7:0] JGE   = 8'h25;
   localparam logic [7:0] JMP   = 8'h26;
   localparam logic [7:0] SWI   = 8'h2A;
   localparam logic [7:0] CALL  = 8'h2B;
   localparam logic [7:0] RET   = 8'h2C;
   localparam logic [7:0] IRET  = 8'h2D;
   localparam logic [7:0] PUSH  = 8'h30;
   localparam logic [7:0] POP   = 8'h31;
   localparam logic [7:0] PUSHB = 8'h32;
   localparam logic [7:0] POPB  = 8'h33;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } fetch_state_t;

   // Instructions are word-aligned; low address bits are dropped
   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return addr & ~WORD_W'(3);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu0_ifq.sv
`default_nettype none
// ============================================================================
//  Module      : cpu0_ifq
//  Description : DEPTH-entry instruction queue of {pc, word} pairs with
//                flush (highest priority), push, pop and occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu0_ifq
   import cpu0_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    flush,
   input  logic                    push,
   input  logic [WORD_W-1:0]       push_pc,
   input  logic [WORD_W-1:0]       push_word,
   input  logic                    pop,
   output logic                    valid,
   output logic [WORD_W-1:0]       head_pc,
   output logic [WORD_W-1:0]       head_word,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [WORD_W-1:0] pc_mem   [DEPTH];
   logic [WORD_W-1:0] word_mem [DEPTH];
   logic              pop_fire;
   logic              write_en;

   // A pop on an empty queue is ignored; flush overrides both push and pop
   assign pop_fire  = pop && valid && !flush;
   assign write_en  = push && !flush;
   assign valid     = (count != '0);
   assign head_pc   = pc_mem[rd_ptr];
   assign head_word = word_mem[rd_ptr];

   // Storage array: cleared at reset so the head reads zero before any push
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem[i]   <= '0;
            word_mem[i] <= '0;
         end
      end else if (write_en) begin
         pc_mem[wr_ptr]   <= push_pc;
         word_mem[wr_ptr] <= push_word;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (write_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
         case ({write_en, pop_fire})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/cpu0_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : cpu0_fetch
//  Description : CPU0 instruction prefetch. Reads bytes from a byte-wide
//                memory port, assembles big-endian 32-bit words and queues
//                them with their address for the execute stage.
//                Optional trace output: define CPU0_FETCH_TRACE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu0_fetch
   import cpu0_pkg::*;
#(
   parameter int unsigned        DEPTH    = 4,
   parameter logic [WORD_W-1:0]  RESET_PC = 32'h0
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               redirect,
   input  logic [WORD_W-1:0]  redirect_pc,
   output logic               mem_req,
   output logic [WORD_W-1:0]  mem_addr,
   input  logic [7:0]         mem_rdata,
   input  logic               mem_ack,
   output logic               ir_valid,
   output logic [WORD_W-1:0]  ir,
   output logic [WORD_W-1:0]  ir_pc,
   input  logic               ir_ready
);

   localparam int unsigned      CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   fetch_state_t      state;
   logic [1:0]        b;
   logic [WORD_W-1:0] fetch_pc;
   logic [23:0]       partial;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  net_count;
   logic              pop_fire;
   logic              push;
   logic              slot_now;
   logic              slot_after;

   // A same-cycle pop already counts as a freed slot
   assign pop_fire   = ir_valid && ir_ready;
   assign net_count  = count - (pop_fire ? ONE : '0);
   assign slot_now   = net_count < FULL;
   assign slot_after = (net_count + ONE) < FULL;
   // The 4th byte goes straight into the queue alongside the three held bytes
   assign push       = (state == FETCH) && mem_ack && (b == 2'd3) && !redirect;

   // Fetch sequencer: byte index, word address, byte assembly and memory request
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= RESET_PC;
         fetch_pc <= RESET_PC;
         b        <= '0;
         partial  <= '0;
      end else if (redirect) begin
         state    <= FETCH;
         mem_req  <= 1'b1;
         fetch_pc <= word_align(redirect_pc);
         mem_addr <= word_align(redirect_pc);
         b        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (slot_now) begin
                  state   <= FETCH;
                  mem_req <= 1'b1;
               end
            end
            FETCH: begin
               if (mem_ack) begin
                  if (b == 2'd3) begin
                     fetch_pc <= fetch_pc + 32'd4;
                     mem_addr <= fetch_pc + 32'd4;
                     b        <= '0;
                     if (!slot_after) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                     end
                  end else begin
                     partial  <= {partial[15:0], mem_rdata};
                     mem_addr <= mem_addr + 32'd1;
                     b        <= b + 2'd1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   cpu0_ifq #(
      .DEPTH (DEPTH)
   ) u_ifq (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (redirect),
      .push      (push),
      .push_pc   (fetch_pc),
      .push_word ({partial, mem_rdata}),
      .pop       (pop_fire),
      .valid     (ir_valid),
      .head_pc   (ir_pc),
      .head_word (ir),
      .count     (count)
   );

`ifdef CPU0_FETCH_TRACE_EN
   // Simulation trace of queued words and redirects
   always @(posedge clock) begin
      if (reset_n) begin
         if (redirect)
            $display("%4dns REDIRECT %8x", $stime, word_align(redirect_pc));
         else if (push)
            $display("%4dns %8x : FETCH %8x", $stime, fetch_pc, {partial, mem_rdata});
      end
   end
`else
   // Tracing compiled out
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu0_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu0_fetch
//  Description : Self-checking bench for cpu0_fetch. Memory contents come
//                from an address hash; every popped word must equal the next
//                contiguous word of that memory from the last redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu0_fetch;
   import cpu0_pkg::*;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        mem_ack = 1'b0;
   logic        ir_valid;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic        ir_ready = 1'b0;

   int          tests = 0;
   int          failed = 0;
   int          cyc = 0;
   int          n_pops = 0;
   int          last_pop = 0;
   int          prev_pop = 0;
   logic [31:0] exp_pc = '0;

   cpu0_fetch #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .ir_valid    (ir_valid),
      .ir          (ir),
      .ir_pc       (ir_pc),
      .ir_ready    (ir_ready)
   );

   always #5 clock = ~clock;

   // Memory image: the program 00 1F 00 28 at address 0, hashed bytes elsewhere
   function automatic logic [7:0] membyte(input logic [31:0] a);
      logic [7:0] v;
      case (a)
         32'd0:   v = 8'h00;
         32'd1:   v = 8'h1F;
         32'd2:   v = 8'h00;
         32'd3:   v = 8'h28;
         default: v = (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] pc);
      return {membyte(pc), membyte(pc + 32'd1), membyte(pc + 32'd2), membyte(pc + 32'd3)};
   endfunction

   assign mem_rdata = membyte(mem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One clock of stimulus; pops are checked against the contiguous-stream model
   task automatic drive_cycle(input logic ack, input logic rdy, input logic rd,
                              input logic [31:0] rpc);
      logic        popping;
      logic        hold;
      logic [31:0] addr_before;
      mem_ack     = ack;
      ir_ready    = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      popping     = ir_valid && rdy && !rd;
      if (popping) begin
         check("pop_pc", ir_pc, exp_pc);
         check("pop_word", ir, exp_word(exp_pc));
         exp_pc   = exp_pc + 32'd4;
         n_pops++;
         prev_pop = last_pop;
         last_pop = cyc;
      end
      if (rd) exp_pc = rpc & ~32'h3;
      hold        = mem_req && !ack && !rd;
      addr_before = mem_addr;
      tick();
      cyc++;
      if (hold) begin
         check("hold_addr", mem_addr, addr_before);
         check("hold_req", {31'b0, mem_req}, 32'd1);
      end
      redirect = 1'b0;
   endtask

   initial begin
      int pops_before;

      // Reset state
      repeat (2) tick();
      check("rst_req", {31'b0, mem_req}, 32'd0);
      check("rst_valid", {31'b0, ir_valid}, 32'd0);
      check("rst_ir", ir, 32'd0);
      check("rst_ir_pc", ir_pc, 32'd0);
      check("rst_addr", mem_addr, RESET_PC);

      // Zero-wait first word: addresses 0..3 then 001F0028 at pc 0
      reset_n = 1'b1;
      mem_ack = 1'b1;
      tick();
      check("entry_req", {31'b0, mem_req}, 32'd1);
      exp_pc = RESET_PC;
      for (int k = 0; k < 4; k++) begin
         check("seq_addr", mem_addr, 32'(k));
         drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      end
      check("first_valid", {31'b0, ir_valid}, 32'd1);
      check("first_ir", ir, 32'h001F0028);
      check("first_pc", ir_pc, 32'd0);

      // Stalled consumer: queue fills to DEPTH words, then fetch idles
      repeat (12) drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("full_req", {31'b0, mem_req}, 32'd0);
      repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("full_req_held", {31'b0, mem_req}, 32'd0);
      check("full_head", ir_pc, 32'd0);
      drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("resume_req", {31'b0, mem_req}, 32'd1);
      check("resume_addr", mem_addr, 32'h10);
      check("resume_head", ir_pc, 32'h4);

      // Ack every third cycle: addresses held, one word per 12 cycles
      for (int i = 0; i < 84; i++)
         drive_cycle((i % 3) == 2, 1'b1, 1'b0, 32'd0);
      check("wait_period", 32'(last_pop - prev_pop), 32'd12);

      // Redirect mid-word with two entries queued
      drive_cycle(1'b0, 1'b0, 1'b1, 32'd0);
      repeat (10) drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("pre_redir_valid", {31'b0, ir_valid}, 32'd1);
      check("pre_redir_addr", mem_addr, 32'h0A);
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h43);
      check("redir_valid", {31'b0, ir_valid}, 32'd0);
      check("redir_addr", mem_addr, 32'h40);
      check("redir_req", {31'b0, mem_req}, 32'd1);
      repeat (4) drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("redir_word_valid", {31'b0, ir_valid}, 32'd1);
      check("redir_word_pc", ir_pc, 32'h40);
      check("redir_word", ir, exp_word(32'h40));

      // Redirect, ack and pop all in one cycle
      repeat (6) drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      drive_cycle(1'b1, 1'b1, 1'b1, 32'h100);
      check("coll_valid", {31'b0, ir_valid}, 32'd0);
      check("coll_addr", mem_addr, 32'h100);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
         check("coll_no_stale", {31'b0, ir_valid}, 32'd0);
      end
      drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("coll_word_valid", {31'b0, ir_valid}, 32'd1);
      check("coll_word_pc", ir_pc, 32'h100);
      check("coll_word", ir, exp_word(32'h100));

      // Asynchronous reset between clock edges, mid-word
      repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_req", {31'b0, mem_req}, 32'd0);
      check("async_valid", {31'b0, ir_valid}, 32'd0);
      check("async_addr", mem_addr, RESET_PC);
      check("async_ir", ir, 32'd0);
      tick();
      reset_n = 1'b1;
      exp_pc  = RESET_PC;

      // Randomized traffic with occasional redirects
      pops_before = n_pops;
      for (int i = 0; i < 800; i++)
         drive_cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                     $urandom_range(0, 99) < 3, $urandom);
      repeat (20) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("rand_progress", {31'b0, (n_pops - pops_before) > 40}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
